ex_mem_skid_stage: RTL and testbench

Parametrised EX/MEM pipeline stage with a valid/ready handshake and a two-entry skid buffer. It carries the write-back control, memory control, data-memory address, store data and destination register from EX to MEM. Unlike a plain clocked register, it supports back-pressure from MEM (stall), flush, and bubble insertion. Control outputs read zero whenever the stage holds no valid entry. It sits between the EX-stage ALU/forwarding logic and the data-memory interface.

---
 rtl/ex_mem_skid_stage.sv | 120 ++++++++++++
 tb/tb_ex_mem_skid_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid_stage.sv
// EX/MEM pipeline stage: valid/ready handshake in front of a two-entry skid buffer
// (OUT + SKID). Control fields read zero whenever no valid entry is held.
module ex_mem_skid_stage #(
  parameter int WB_W   = 2,
  parameter int M_W    = 2,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WB_W-1:0]   WB_i,
  input  logic [M_W-1:0]    M_i,
  input  logic [DATA_W-1:0] DMaddr_i,
  input  logic [DATA_W-1:0] DMdata_i,
  input  logic [REG_W-1:0]  RDaddr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WB_W-1:0]   WB_o,
  output logic [M_W-1:0]    M_o,
  output logic [DATA_W-1:0] DMaddr_o,
  output logic [DATA_W-1:0] DMdata_o,
  output logic [REG_W-1:0]  RDaddr_o,
  output logic [1:0]        count_o
);

  // Handshake: an entry moves when valid & ready are both high at a rising edge.
  // in_ready_o depends only on registered state, never on out_ready_i.

  localparam int PW      = WB_W + M_W + 2 * DATA_W + REG_W;
  localparam int RD_LSB  = 0;
  localparam int DAT_LSB = REG_W;
  localparam int ADR_LSB = REG_W + DATA_W;
  localparam int M_LSB   = REG_W + 2 * DATA_W;
  localparam int WB_LSB  = REG_W + 2 * DATA_W + M_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] out_q, out_d;
  logic [PW-1:0] skid_q, skid_d;
  logic [PW-1:0] in_pack;
  logic          out_valid;
  logic          skid_valid;
  logic          accept;
  logic          consume;

  assign in_pack    = {WB_i, M_i, DMaddr_i, DMdata_i, RDaddr_i};
  assign out_valid  = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL);
  assign accept     = in_valid_i & ~skid_valid;
  assign consume    = out_valid & out_ready_i;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Flush drops both held entries and anything presented this cycle.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            out_d   = in_pack;
          end
        end
        ONE: begin
          if (accept && consume) begin
            out_d = in_pack;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_pack;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // SKID is always older than any new input, so it moves first.
          if (consume) begin
            state_d = ONE;
            out_d   = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign in_ready_o  = ~skid_valid;
  assign out_valid_o = out_valid;
  assign count_o     = {1'b0, out_valid} + {1'b0, skid_valid};

  // Bubble: WB/M forced to zero so downstream sees a nop.
  assign WB_o     = out_valid ? out_q[WB_LSB +: WB_W] : '0;
  assign M_o      = out_valid ? out_q[M_LSB +: M_W] : '0;
  assign DMaddr_o = out_q[ADR_LSB +: DATA_W];
  assign DMdata_o = out_q[DAT_LSB +: DATA_W];
  assign RDaddr_o = out_q[RD_LSB +: REG_W];

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Bench for ex_mem_skid_stage: directed scenarios plus random traffic, all checked
// against a two-deep FIFO reference model held in a queue.
module tb_ex_mem_skid_stage;

  typedef struct packed {
    logic [1:0]  wb;
    logic [1:0]  m;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
  } entry_t;

  localparam int EW = $bits(entry_t);
  localparam int VW = 4 + EW;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  entry_t in_e;
  logic out_valid, in_ready;
  logic [1:0] count, wb_o, m_o;
  logic [31:0] addr_o, data_o;
  logic [4:0] rd_o;

  logic w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [2:0] w_wb_i, w_wb_o;
  logic [1:0] w_m_i, w_m_o, w_count;
  logic [63:0] w_addr_i, w_data_i, w_addr_o, w_data_o;
  logic [5:0] w_rd_i, w_rd_o;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_out;
  logic [VW-1:0] obs;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ex_mem_skid_stage dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .WB_i(in_e.wb), .M_i(in_e.m), .DMaddr_i(in_e.addr), .DMdata_i(in_e.data), .RDaddr_i(in_e.rd),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .WB_o(wb_o), .M_o(m_o), .DMaddr_o(addr_o), .DMdata_o(data_o), .RDaddr_o(rd_o),
    .count_o(count)
  );

  ex_mem_skid_stage #(.WB_W(3), .M_W(2), .DATA_W(64), .REG_W(6)) dut_w (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(w_in_valid), .in_ready_o(w_in_ready),
    .WB_i(w_wb_i), .M_i(w_m_i), .DMaddr_i(w_addr_i), .DMdata_i(w_data_i), .RDaddr_i(w_rd_i),
    .out_valid_o(w_out_valid), .out_ready_i(w_out_ready),
    .WB_o(w_wb_o), .M_o(w_m_o), .DMaddr_o(w_addr_o), .DMdata_o(w_data_o), .RDaddr_o(w_rd_o),
    .count_o(w_count)
  );

  assign obs = {out_valid, in_ready, count, wb_o, m_o, addr_o, data_o, rd_o};

  function automatic entry_t mk(logic [1:0] wb, logic [1:0] m, logic [4:0] rd);
    entry_t e;
    e.wb = wb; e.m = m; e.addr = $urandom; e.data = $urandom; e.rd = rd;
    return e;
  endfunction

  // Expected observable view: queue head when non-empty, otherwise a nop with the
  // last entry that reached the output register still on the data fields.
  function automatic logic [VW-1:0] model_view();
    entry_t e;
    logic v;
    logic r;
    logic [1:0] c;
    v = (exp_q.size() > 0);
    r = (exp_q.size() < 2);
    c = 2'(exp_q.size());
    e = v ? entry_t'(exp_q[0]) : entry_t'(last_out);
    return {v, r, c, (v ? e.wb : 2'b00), (v ? e.m : 2'b00), e.addr, e.data, e.rd};
  endfunction

  // Advance one clock edge and apply the FIFO rules to the model.
  task automatic tick();
    logic acc, con, r, f;
    logic [EW-1:0] cur;
    acc = in_valid && (exp_q.size() < 2);
    con = out_ready && (exp_q.size() > 0);
    r = rst; f = flush; cur = in_e;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      last_out = '0;
    end else if (f) begin
      exp_q.delete();
    end else begin
      if (con) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(cur);
    end
    if (exp_q.size() > 0) last_out = exp_q[0];
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    in_e = mk(2'b11, 2'b11, 5'd7);
    w_in_valid = 1'b1; w_out_ready = 1'b0;
    tick();
    n_checks++; if (obs !== model_view()) begin n_errors++; $display("FAIL reset_view: got %h exp %h", obs, model_view()); end
    n_checks++; if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_flags: got v=%b c=%0d r=%b exp v=0 c=0 r=1", out_valid, count, in_ready); end
    n_checks++; if ({wb_o, m_o, addr_o, data_o, rd_o} !== '0) begin n_errors++; $display("FAIL reset_data: got %h exp 0", {wb_o, m_o, addr_o, data_o, rd_o}); end
    n_checks++; if (w_out_valid !== 1'b0 || w_addr_o !== 64'd0 || w_rd_o !== 6'd0) begin n_errors++; $display("FAIL reset_wide: got v=%b a=%h rd=%0d exp 0", w_out_valid, w_addr_o, w_rd_o); end
    rst = 1'b0; in_valid = 1'b0; w_in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_drop: got v=%b exp 0", out_valid); end
  endtask

  task automatic test_stream();
    drain();
    in_valid = 1'b1; in_e = mk(2'b11, 2'b01, 5'd1);
    tick();
    n_checks++; if (out_valid !== 1'b1 || rd_o !== 5'd1 || wb_o !== 2'b11 || count !== 2'd1) begin n_errors++; $display("FAIL stream_a: got v=%b rd=%0d wb=%b c=%0d exp v=1 rd=1 wb=11 c=1", out_valid, rd_o, wb_o, count); end
    in_e = mk(2'b01, 2'b10, 5'd2);
    tick();
    n_checks++; if (rd_o !== 5'd2 || count !== 2'd1 || obs !== model_view()) begin n_errors++; $display("FAIL stream_b: got rd=%0d c=%0d exp rd=2 c=1", rd_o, count); end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin n_errors++; $display("FAIL stream_end: got v=%b c=%0d exp v=0 c=0", out_valid, count); end
  endtask

  task automatic test_stall_skid();
    drain();
    in_valid = 1'b1; in_e = mk(2'b10, 2'b01, 5'd10);
    tick();
    out_ready = 1'b0; in_e = mk(2'b01, 2'b10, 5'd11);
    tick();
    n_checks++; if (rd_o !== 5'd10 || count !== 2'd2 || in_ready !== 1'b0) begin n_errors++; $display("FAIL stall_full: got rd=%0d c=%0d r=%b exp rd=10 c=2 r=0", rd_o, count, in_ready); end
    in_e = mk(2'b11, 2'b11, 5'd12);
    tick();
    n_checks++; if (rd_o !== 5'd10 || count !== 2'd2 || obs !== model_view()) begin n_errors++; $display("FAIL stall_hold: got rd=%0d c=%0d exp rd=10 c=2", rd_o, count); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (rd_o !== 5'd11 || count !== 2'd1 || in_ready !== 1'b1) begin n_errors++; $display("FAIL release_b: got rd=%0d c=%0d r=%b exp rd=11 c=1 r=1", rd_o, count, in_ready); end
    tick();
    n_checks++; if (rd_o !== 5'd12 || count !== 2'd1 || wb_o !== 2'b11) begin n_errors++; $display("FAIL release_c: got rd=%0d c=%0d wb=%b exp rd=12 c=1 wb=11", rd_o, count, wb_o); end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin n_errors++; $display("FAIL release_end: got v=%b c=%0d exp v=0 c=0", out_valid, count); end
  endtask

  task automatic test_flush_full();
    drain();
    out_ready = 1'b0; in_valid = 1'b1;
    in_e = mk(2'b11, 2'b11, 5'd20); tick();
    in_e = mk(2'b11, 2'b11, 5'd21); tick();
    n_checks++; if (count !== 2'd2) begin n_errors++; $display("FAIL flush_pre: got c=%0d exp c=2", count); end
    flush = 1'b1; in_e = mk(2'b11, 2'b11, 5'd22);
    tick();
    n_checks++; if (out_valid !== 1'b0 || wb_o !== 2'b00 || m_o !== 2'b00 || count !== 2'd0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL flush_full: got v=%b wb=%b m=%b c=%0d r=%b exp 0 0 0 0 1", out_valid, wb_o, m_o, count, in_ready); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0 || rd_o === 5'd22) begin n_errors++; $display("FAIL flush_drop: got v=%b rd=%0d exp v=0", out_valid, rd_o); end
  endtask

  task automatic test_bubble();
    logic [31:0] a;
    drain();
    in_valid = 1'b1; in_e = mk(2'b10, 2'b01, 5'd5); a = in_e.addr;
    tick();
    n_checks++; if (wb_o !== 2'b10 || m_o !== 2'b01 || addr_o !== a) begin n_errors++; $display("FAIL bubble_load: got wb=%b m=%b a=%h exp 10 01 %h", wb_o, m_o, addr_o, a); end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0 || wb_o !== 2'b00 || m_o !== 2'b00 || addr_o !== a) begin n_errors++; $display("FAIL bubble_zero: got v=%b wb=%b m=%b a=%h exp 0 00 00 %h", out_valid, wb_o, m_o, addr_o, a); end
  endtask

  task automatic test_back_to_back();
    drain();
    in_valid = 1'b1; in_e = mk(2'b01, 2'b01, 5'd30);
    tick();
    in_e = mk(2'b10, 2'b10, 5'd31);
    tick();
    n_checks++; if (rd_o !== 5'd31 || count !== 2'd1 || in_ready !== 1'b1 || obs !== model_view()) begin n_errors++; $display("FAIL accept_consume: got rd=%0d c=%0d r=%b exp rd=31 c=1 r=1", rd_o, count, in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_param_sweep();
    w_out_ready = 1'b1; w_in_valid = 1'b1;
    w_wb_i = 3'b101; w_m_i = 2'b10; w_addr_i = 64'hFFFF_0000_1234_5678;
    w_data_i = 64'h0123_4567_89AB_CDEF; w_rd_i = 6'd63;
    tick();
    n_checks++; if (w_out_valid !== 1'b1 || w_addr_o !== 64'hFFFF_0000_1234_5678 || w_rd_o !== 6'd63) begin n_errors++; $display("FAIL wide_fields: got v=%b a=%h rd=%0d exp 1 ffff000012345678 63", w_out_valid, w_addr_o, w_rd_o); end
    n_checks++; if (w_wb_o !== 3'b101 || w_m_o !== 2'b10 || w_data_o !== 64'h0123_4567_89AB_CDEF) begin n_errors++; $display("FAIL wide_ctrl: got wb=%b m=%b d=%h", w_wb_o, w_m_o, w_data_o); end
    w_in_valid = 1'b0;
    tick();
    n_checks++; if (w_out_valid !== 1'b0 || w_wb_o !== 3'b000 || w_count !== 2'd0) begin n_errors++; $display("FAIL wide_bubble: got v=%b wb=%b c=%0d exp 0 000 0", w_out_valid, w_wb_o, w_count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      rst       = ($urandom_range(0, 60) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_e      = mk(2'($urandom), 2'($urandom), 5'($urandom));
      tick();
      n_checks++; if (obs !== model_view()) begin n_errors++; $display("FAIL random[%0d]: got %h exp %h", i, obs, model_view()); end
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_e = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b0; w_wb_i = '0; w_m_i = '0;
    w_addr_i = '0; w_data_i = '0; w_rd_i = '0;
    last_out = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall_skid();
    test_flush_full();
    test_bubble();
    test_back_to_back();
    test_param_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
